// File: rtl/dac_quad_seq.sv
// Four-channel setpoint store that sequences dirty channels into 16-bit DAC command
// words. Frames are strobed no closer than XFER_CYCLES+GAP clocks apart.
module dac_quad_seq #(
    parameter int XFER_CYCLES = 64,
    parameter int GAP         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iocs,
    input  logic        iowr,
    input  logic [1:0]  ioa,
    input  logic [11:0] din,
    output logic        busy,
    output logic [3:0]  pending,
    output logic        spi_cs,
    output logic        spi_wr,
    output logic [15:0] spi_dout
);
    localparam int FRAME = XFER_CYCLES + GAP;
    localparam int CNT_W = $clog2(FRAME);
    // ISSUE plus CNT_LOAD+1 WAIT clocks gives a strobe-to-strobe spacing of FRAME
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [11:0]      setpoint_reg [4];
    logic [3:0]       pending_reg, pending_next;
    logic [3:0]       wr_mask, clr_mask;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             spi_wr_reg, spi_wr_next;
    logic [15:0]      spi_dout_reg, spi_dout_next;
    logic [1:0]       sel_ch;
    logic [1:0]       cmd;
    logic             host_wr;

    assign host_wr = iocs & iowr;
    assign wr_mask = host_wr ? (4'b0001 << ioa) : 4'b0000;

    always_comb begin
        sel_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_reg[i]) sel_ch = 2'(i);
        end
    end

    assign clr_mask = (state_reg == ISSUE) ? (4'b0001 << sel_ch) : 4'b0000;

    // A host write landing on the issue clock re-arms the channel being cleared
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pend
            assign pending_next[gi] = wr_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
        end
    endgenerate

    // Update-all only when nothing is left to send after this word
    assign cmd = (pending_next == 4'b0000) ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|pending_reg) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (cnt_reg == '0) state_next = (|pending_reg) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spi_wr_next   = 1'b0;
        spi_dout_next = spi_dout_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            ISSUE: begin
                spi_wr_next   = 1'b1;
                spi_dout_next = {cmd, sel_ch, setpoint_reg[sel_ch]};
                cnt_next      = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg  <= 4'b0000;
            cnt_reg      <= '0;
            spi_wr_reg   <= 1'b0;
            spi_dout_reg <= 16'h0000;
            for (int i = 0; i < 4; i++) setpoint_reg[i] <= 12'h000;
        end else begin
            pending_reg  <= pending_next;
            cnt_reg      <= cnt_next;
            spi_wr_reg   <= spi_wr_next;
            spi_dout_reg <= spi_dout_next;
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) setpoint_reg[i] <= din;
            end
        end
    end

    assign busy     = (state_reg != IDLE) | (|pending_reg);
    assign pending  = pending_reg;
    assign spi_cs   = spi_wr_reg;
    assign spi_wr   = spi_wr_reg;
    assign spi_dout = spi_dout_reg;

endmodule

// File: tb/tb_dac_quad_seq.sv
// Randomised and directed bench for dac_quad_seq: a timing-rule reference model
// predicts every DAC word and its clock, and a negedge monitor checks them.
module tb_dac_quad_seq;
    localparam int FRAME = 68;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iocs = 1'b0;
    logic        iowr = 1'b0;
    logic [1:0]  ioa = 2'd0;
    logic [11:0] din = 12'h000;
    logic        busy;
    logic [3:0]  pending;
    logic        spi_cs;
    logic        spi_wr;
    logic [15:0] spi_dout;

    dac_quad_seq dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iowr     (iowr),
        .ioa      (ioa),
        .din      (din),
        .busy     (busy),
        .pending  (pending),
        .spi_cs   (spi_cs),
        .spi_wr   (spi_wr),
        .spi_dout (spi_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] seen_words[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_strobes = 0;

    // reference model state, updated once per rising edge
    bit   [3:0]  m_pend = 4'b0000;
    logic [11:0] m_sp[4];
    int          m_pw[4];
    int          m_last = -1000;
    int          m_rst_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a word goes out at the first edge that is a full frame after the last
    // strobe and at least two edges after the oldest pending write.
    initial begin
        for (int i = 0; i < 4; i++) begin
            m_sp[i] = 12'h000;
            m_pw[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_pend    = 4'b0000;
                m_last    = -1000;
                m_rst_cyc = cyc;
                for (int i = 0; i < 4; i++) m_sp[i] = 12'h000;
            end else begin
                bit   wr_now;
                bit   do_issue;
                int   oldest;
                int   n;
                bit   [3:0] rem;
                logic [1:0] c;
                exp_t e;
                wr_now   = iocs && iowr;
                do_issue = 1'b0;
                oldest   = 1 << 30;
                n        = 0;
                for (int i = 0; i < 4; i++) if (m_pend[i] && m_pw[i] < oldest) oldest = m_pw[i];
                if (m_pend != 0 && cyc >= m_last + FRAME && cyc >= oldest + 2) do_issue = 1'b1;
                if (do_issue) begin
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) n = i;
                    rem = m_pend;
                    rem[n] = 1'b0;
                    if (wr_now) rem[ioa] = 1'b1;
                    c = (rem == 0) ? 2'b10 : 2'b01;
                    e.edge_n = cyc;
                    e.word   = {c, 2'(n), m_sp[n]};
                    exp_q.push_back(e);
                    m_pend[n] = 1'b0;
                    m_last    = cyc;
                end
                if (wr_now) begin
                    m_sp[ioa] = din;
                    if (!m_pend[ioa]) begin
                        m_pend[ioa] = 1'b1;
                        m_pw[ioa]   = cyc;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on every strobe, plus per-cycle status checks
    initial begin
        bit prev_wr;
        int last_seen;
        exp_t e;
        prev_wr   = 1'b0;
        last_seen = -1000;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("cs_eq_wr", {31'd0, spi_cs}, {31'd0, spi_wr});
                check("pending", {28'd0, pending}, {28'd0, m_pend});
                check("busy", {31'd0, busy}, {31'd0, (m_pend != 0) || (cyc <= m_last + FRAME - 2)});
                if (spi_wr) begin
                    n_strobes++;
                    seen_words.push_back(spi_dout);
                    checks++;
                    if (prev_wr) begin
                        errors++;
                        $display("FAIL strobe_consecutive: got strobe at %0d and %0d required gap", cyc - 1, cyc);
                    end
                    if (last_seen > m_rst_cyc) begin
                        checks++;
                        if (cyc - last_seen < FRAME) begin
                            errors++;
                            $display("FAIL strobe_gap: got %0d required >= %0d", cyc - last_seen, FRAME);
                        end
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_strobe: got word %04h at %0d required none", spi_dout, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_word", {16'd0, spi_dout}, {16'd0, e.word});
                        check("strobe_cycle", cyc, e.edge_n);
                    end
                    last_seen = cyc;
                end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_strobe: got none at %0d required word %04h", cyc, exp_q[0].word);
                    e = exp_q.pop_front();
                end
                prev_wr = spi_wr;
            end
        end
    end

    task automatic wr(input logic [1:0] ch, input logic [11:0] d);
        @(negedge clk);
        iocs = 1'b1;
        iowr = 1'b1;
        ioa  = ch;
        din  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            iocs = 1'b0;
            iowr = 1'b0;
            ioa  = 2'($urandom_range(0, 3));
            din  = 12'($urandom);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            idle(1);
            k++;
        end
        check("wait_idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_strobe(output int at);
        int k;
        k  = 0;
        at = -1;
        while (k < 300 && at < 0) begin
            idle(1);
            if (spi_wr) at = cyc;
            k++;
        end
        check("wait_strobe_found", {31'd0, at >= 0}, 32'd1);
    endtask

    initial begin
        int t;
        int at;
        int s0;
        int n;
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_wr", {31'd0, spi_wr}, 32'd0);
        check("rst_dout", {16'd0, spi_dout}, 32'd0);

        // single write, latency and busy release
        wr(2'd2, 12'hABC);
        t = cyc + 1;
        wait_strobe(at);
        check("t1_latency", at - t, 2);
        check("t1_word", {16'd0, spi_dout}, 32'h0000AABC);
        check("t1_pend", {28'd0, pending}, 32'd0);
        idle(FRAME - 2);
        check("t1_busy_hold", {31'd0, busy}, 32'd1);
        idle(1);
        check("t1_busy_low", {31'd0, busy}, 32'd0);

        // four channels back to back
        wait_idle();
        s0 = n_strobes;
        for (int i = 0; i < 4; i++) wr(2'(i), 12'($urandom));
        idle(4 * FRAME + 10);
        check("t2_count", n_strobes - s0, 4);
        n = seen_words.size();
        check("t2_last_cmd", {28'd0, seen_words[n-1][15:12]}, 32'hB);

        // overwrite before issue
        wait_idle();
        s0 = n_strobes;
        wr(2'd1, 12'h111);
        wr(2'd1, 12'h222);
        idle(FRAME + 10);
        check("t3_count", n_strobes - s0, 1);
        check("t3_word", {16'd0, seen_words[seen_words.size()-1]}, 32'h00009222);

        // rewrite landing on the issue clock
        wait_idle();
        s0 = n_strobes;
        wr(2'd1, 12'h111);
        idle(1);
        wr(2'd1, 12'h333);
        idle(FRAME + 10);
        check("t4_count", n_strobes - s0, 2);
        n = seen_words.size();
        check("t4_first", {16'd0, seen_words[n-2]}, 32'h00005111);
        check("t4_second", {16'd0, seen_words[n-1]}, 32'h00009333);

        // reset in the middle of WAIT with work pending
        wait_idle();
        wr(2'd0, 12'h123);
        idle(4);
        wr(2'd2, 12'h456);
        wr(2'd3, 12'h789);
        idle(5);
        check("t5_pend_before", {28'd0, pending}, 32'hC);
        s0 = n_strobes;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_pending", {28'd0, pending}, 32'd0);
        check("t5_wr", {31'd0, spi_wr}, 32'd0);
        check("t5_cs", {31'd0, spi_cs}, 32'd0);
        check("t5_dout", {16'd0, spi_dout}, 32'd0);
        idle(200);
        check("t5_no_strobe", n_strobes - s0, 0);

        // random traffic in blocks of varying density
        for (int b = 0; b < 20; b++) begin
            int dens;
            dens = $urandom_range(0, 3);
            for (int k = 0; k < 500; k++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < dens * 6) begin
                    wr(2'($urandom_range(0, 3)), 12'($urandom));
                end else if (r > 96) begin
                    @(negedge clk);
                    iocs = r[0];
                    iowr = ~r[0];
                    ioa  = 2'($urandom_range(0, 3));
                    din  = 12'($urandom);
                end else begin
                    idle(1);
                end
            end
        end
        idle(5 * FRAME);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_pending", {28'd0, pending}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
